// File: rtl/seg7_scan_reader_if.sv
// rtl/seg7_scan_reader_if.sv - display-pin and result bundle for the 7-segment scan reader
interface seg7_scan_reader_if #(
  parameter int DIGITS = 4
);
  logic [6:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic                err_clr;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   digit_valid;
  logic                pattern_err;
  logic                err_sticky;
  logic                frame_done;

  modport master (
    output seg_n, an_n, err_clr,
    input  value, digit_valid, pattern_err, err_sticky, frame_done
  );

  modport slave (
    input  seg_n, an_n, err_clr,
    output value, digit_valid, pattern_err, err_sticky, frame_done
  );
endinterface

// File: rtl/seg7_scan_reader.sv
// rtl/seg7_scan_reader.sv - recovers hex digits from a multiplexed active-low 7-segment bus
module seg7_scan_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_reader_if.slave  bus
);
  localparam int              W      = DIGITS + 7;
  localparam logic [7:0]      STABLE = 8'(STABLE_CYCLES);

  logic [W-1:0]        sync1_q, sync1_d;
  logic [W-1:0]        sync2_q, sync2_d;
  logic [W-1:0]        prev_q, prev_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] value_q, value_d;
  logic [DIGITS-1:0]   valid_q, valid_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                perr_q, perr_d;
  logic                sticky_q, sticky_d;
  logic                fdone_q, fdone_d;

  logic                changed;
  logic                fire;
  logic [DIGITS-1:0]   an_sel;
  logic [6:0]          seg_on;
  logic [4:0]          dec;

  // Returns {legal, nibble}; blank and unknown codes both report not legal.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = {1'b1, 4'h0};
      7'h06: decode = {1'b1, 4'h1};
      7'h5B: decode = {1'b1, 4'h2};
      7'h4F: decode = {1'b1, 4'h3};
      7'h66: decode = {1'b1, 4'h4};
      7'h6D: decode = {1'b1, 4'h5};
      7'h7D: decode = {1'b1, 4'h6};
      7'h07: decode = {1'b1, 4'h7};
      7'h7F: decode = {1'b1, 4'h8};
      7'h6F: decode = {1'b1, 4'h9};
      7'h77: decode = {1'b1, 4'hA};
      7'h7C: decode = {1'b1, 4'hB};
      7'h39: decode = {1'b1, 4'hC};
      7'h5E: decode = {1'b1, 4'hD};
      7'h79: decode = {1'b1, 4'hE};
      7'h71: decode = {1'b1, 4'hF};
      default: decode = 5'd0;
    endcase
  endfunction

  always_comb begin
    sync1_d  = {bus.an_n, bus.seg_n};
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    value_d  = value_q;
    valid_d  = valid_q;
    mask_d   = mask_q;
    perr_d   = 1'b0;
    fdone_d  = 1'b0;
    dec      = 5'd0;

    changed = (sync2_q != prev_q);
    if (changed) begin
      cnt_d = 8'd1;
    end else if (cnt_q < STABLE) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end

    // prev_q still holds the stable sample on the capture cycle, even if the pins just moved.
    fire   = (cnt_q == STABLE) && !done_q;
    done_d = changed ? 1'b0 : (fire ? 1'b1 : done_q);
    an_sel = ~prev_q[W-1:7];
    seg_on = ~prev_q[6:0];

    if (fire && $onehot(an_sel)) begin
      dec = decode(seg_on);
      for (int i = 0; i < DIGITS; i++) begin
        if (an_sel[i]) begin
          valid_d[i] = dec[4];
          if (dec[4]) begin
            value_d[4*i +: 4] = dec[3:0];
          end
        end
      end
      perr_d = (seg_on != 7'd0) && !dec[4];
      mask_d = mask_q | an_sel;
    end

    if (&mask_d) begin
      fdone_d = 1'b1;
      mask_d  = '0;
    end

    sticky_d = perr_d | (sticky_q & ~bus.err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      value_q  <= '0;
      valid_q  <= '0;
      mask_q   <= '0;
      perr_q   <= 1'b0;
      sticky_q <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      mask_q   <= mask_d;
      perr_q   <= perr_d;
      sticky_q <= sticky_d;
      fdone_q  <= fdone_d;
    end
  end

  assign bus.value       = value_q;
  assign bus.digit_valid = valid_q;
  assign bus.pattern_err = perr_q;
  assign bus.err_sticky  = sticky_q;
  assign bus.frame_done  = fdone_q;
endmodule
